// File: rtl/bpf_seq_pkg.sv
// Shared definitions for the BPF fetch sequencer: phase encoding, default
// program-counter width and the bit positions of the stage-enable vector.
package bpf_seq_pkg;

    localparam int PC_W_DEFAULT = 8;

    // Bit positions inside the stage-enable vector
    localparam int EN_IF  = 0;
    localparam int EN_ID  = 1;
    localparam int EN_EX  = 2;
    localparam int EN_MEM = 3;
    localparam int EN_WB  = 4;
    localparam int EN_NUM = 5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } seqState_t;

endpackage

// File: rtl/seq_pc_target.sv
// Next-PC computation for the fetch sequencer. The target is formed one bit
// wider than the PC so that running past the top of the address space shows
// up as an out-of-range target instead of wrapping back to a legal address.
module seq_pc_target
    import bpf_seq_pkg::*;
#(
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int PROG_LEN = 256
) (
    input  logic [PC_W-1:0] pc,
    input  logic            brP,
    input  logic [PC_W-1:0] offQ,
    output logic [PC_W:0]   target,
    output logic            outOfRange
);

    localparam logic [PC_W:0] LEN_LIM = PROG_LEN[PC_W:0];
    localparam logic [PC_W:0] ONE     = {{PC_W{1'b0}}, 1'b1};

    logic [PC_W:0] addend;

    // Sequential PC plus the forward branch offset when the branch was taken
    always_comb begin
        addend     = brP ? {1'b0, offQ} : '0;
        target     = {1'b0, pc} + ONE + addend;
        outOfRange = (target >= LEN_LIM);
    end

endmodule

// File: rtl/bpf_fetch_sequencer.sv
// Multi-cycle phase controller for the BPF core: owns the program counter and
// walks each instruction through IF, ID, EX, MEM, WB with one-hot enables.
// Optional feature macro: SEQ_RETIRE_CNT_EN adds the oRETIRED counter port.
module bpf_fetch_sequencer
    import bpf_seq_pkg::*;
#(
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int PROG_LEN = 256
) (
    input  logic            iCLK_IF,
    input  logic            iRST,
    input  logic            iSTART,
    input  logic            iSTALL,
    input  logic            iBR_TAKE,
    input  logic [PC_W-1:0] iBR_OFF,
    input  logic            iRET,
    output logic [PC_W-1:0] oPC,
    output logic            oEN_IF,
    output logic            oEN_ID,
    output logic            oEN_EX,
    output logic            oEN_MEM,
    output logic            oEN_WB,
    output logic            oBUSY,
    output logic            oHALT,
    output logic            oFAULT
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]     oRETIRED
`endif
);

    seqState_t         state;
    seqState_t         stateNxt;
    logic              ret_p;
    logic              br_p;
    logic [PC_W-1:0]   off_q;
    logic [PC_W:0]     target;
    logic              outOfRange;
    logic              fault;
    logic [EN_NUM-1:0] en;

    seq_pc_target #(
        .PC_W     (PC_W),
        .PROG_LEN (PROG_LEN)
    ) uTarget (
        .pc         (oPC),
        .brP        (br_p),
        .offQ       (off_q),
        .target     (target),
        .outOfRange (outOfRange)
    );

    // A RET suppresses the range check: returning never faults
    assign fault = outOfRange && !ret_p;

    // Phase register
    always_ff @(posedge iCLK_IF or posedge iRST) begin
        if (iRST) state <= S_IDLE;
        else      state <= stateNxt;
    end

    // Phase sequencing; each input only matters in the phase that samples it
    always_comb begin
        stateNxt = state;
        case (state)
            S_IDLE:  if (iSTART) stateNxt = S_IF;
            S_IF:    stateNxt = S_ID;
            S_ID:    stateNxt = S_EX;
            S_EX:    stateNxt = S_MEM;
            S_MEM:   if (!iSTALL) stateNxt = S_WB;
            S_WB:    stateNxt = (ret_p || fault) ? S_HALT : S_IF;
            S_HALT:  stateNxt = S_HALT;
            default: stateNxt = S_IDLE;
        endcase
    end

    // Stage enables decoded straight from the phase register
    always_comb begin
        en = '0;
        case (state)
            S_IF:    en[EN_IF]  = 1'b1;
            S_ID:    en[EN_ID]  = 1'b1;
            S_EX:    en[EN_EX]  = 1'b1;
            S_MEM:   en[EN_MEM] = 1'b1;
            S_WB:    en[EN_WB]  = 1'b1;
            default: en = '0;
        endcase
    end

    assign oEN_IF  = en[EN_IF];
    assign oEN_ID  = en[EN_ID];
    assign oEN_EX  = en[EN_EX];
    assign oEN_MEM = en[EN_MEM];
    assign oEN_WB  = en[EN_WB];
    assign oBUSY   = (state != S_IDLE) && (state != S_HALT);

    // Execute-result latches and PC/halt update at the writeback edge
    always_ff @(posedge iCLK_IF or posedge iRST) begin
        if (iRST) begin
            ret_p  <= 1'b0;
            br_p   <= 1'b0;
            off_q  <= '0;
            oPC    <= '0;
            oHALT  <= 1'b0;
            oFAULT <= 1'b0;
        end else begin
            if (state == S_EX) begin
                ret_p <= iRET;
                br_p  <= iBR_TAKE;
                off_q <= iBR_OFF;
            end
            if (state == S_WB) begin
                if (ret_p) begin
                    oHALT <= 1'b1;
                end else if (fault) begin
                    oHALT  <= 1'b1;
                    oFAULT <= 1'b1;
                end else begin
                    oPC <= target[PC_W-1:0];
                end
            end
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    // Retired-instruction count, one per writeback including the final one
    always_ff @(posedge iCLK_IF or posedge iRST) begin
        if (iRST)              oRETIRED <= '0;
        else if (state == S_WB) oRETIRED <= oRETIRED + 32'd1;
    end
`endif

endmodule

// File: tb/tb_bpf_fetch_sequencer.sv
// Testbench for bpf_fetch_sequencer: directed scenarios followed by random
// instruction streams, all checked against an instruction-level model.
module tb_bpf_fetch_sequencer;

    localparam int PC_W     = 8;
    localparam int PROG_LEN = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            stall = 1'b0;
    logic            brTake = 1'b0;
    logic [PC_W-1:0] brOff = '0;
    logic            ret = 1'b0;
    logic [PC_W-1:0] oPC;
    logic            oEN_IF, oEN_ID, oEN_EX, oEN_MEM, oEN_WB;
    logic            oBUSY, oHALT, oFAULT;
`ifdef SEQ_RETIRE_CNT_EN
    logic [31:0]     oRETIRED;
`endif

    bpf_fetch_sequencer #(
        .PC_W     (PC_W),
        .PROG_LEN (PROG_LEN)
    ) dut (
        .iCLK_IF  (clk),
        .iRST     (rst),
        .iSTART   (start),
        .iSTALL   (stall),
        .iBR_TAKE (brTake),
        .iBR_OFF  (brOff),
        .iRET     (ret),
        .oPC      (oPC),
        .oEN_IF   (oEN_IF),
        .oEN_ID   (oEN_ID),
        .oEN_EX   (oEN_EX),
        .oEN_MEM  (oEN_MEM),
        .oEN_WB   (oEN_WB),
        .oBUSY    (oBUSY),
        .oHALT    (oHALT),
        .oFAULT   (oFAULT)
`ifdef SEQ_RETIRE_CNT_EN
        ,
        .oRETIRED (oRETIRED)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErr    = 0;

    // Instruction-level reference state
    int pcM;
    bit haltM;
    bit faultM;
    int retM;

    // Phase codes as seen on {WB,MEM,EX,ID,IF}
    localparam logic [31:0] PH_NONE = 32'd0;
    localparam logic [31:0] PH_IF   = 32'd1;
    localparam logic [31:0] PH_ID   = 32'd2;
    localparam logic [31:0] PH_EX   = 32'd4;
    localparam logic [31:0] PH_MEM  = 32'd8;
    localparam logic [31:0] PH_WB   = 32'd16;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enVec();
        return 32'({oEN_WB, oEN_MEM, oEN_EX, oEN_ID, oEN_IF});
    endfunction

    task automatic chkRet(input string tag);
`ifdef SEQ_RETIRE_CNT_EN
        chk(tag, oRETIRED, 32'(retM));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic chkFlags(input string tag);
        chk({tag, "_pc"},    32'(oPC),    32'(pcM));
        chk({tag, "_halt"},  32'(oHALT),  32'(haltM));
        chk({tag, "_fault"}, 32'(oFAULT), 32'(faultM));
        chkRet({tag, "_ret"});
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge
    task automatic doReset(input string tag);
        start = 0; stall = 0; brTake = 0; brOff = '0; ret = 0;
        rst = 0;
        #1 rst = 1;
        #1;
        pcM = 0; haltM = 0; faultM = 0; retM = 0;
        chk({tag, "_en"},   enVec(),       PH_NONE);
        chk({tag, "_busy"}, 32'(oBUSY),    32'd0);
        chkFlags(tag);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk({tag, "_idle_en"}, enVec(), PH_NONE);
    endtask

    task automatic doStart();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic chkHalted(input string tag);
        chk({tag, "_en"},   enVec(),    PH_NONE);
        chk({tag, "_busy"}, 32'(oBUSY), 32'd0);
        chkFlags(tag);
    endtask

    // One instruction: sequence of phases, inputs valid only in their phase
    task automatic runInstr(input string tag, input int stalls, input bit br,
                            input int off, input bit r);
        logic [31:0] phases[$];
        int memIdx = 0;
        int t;
        phases.push_back(PH_IF);
        phases.push_back(PH_ID);
        phases.push_back(PH_EX);
        for (int i = 0; i <= stalls; i++) phases.push_back(PH_MEM);
        phases.push_back(PH_WB);
        foreach (phases[k]) begin
            chk({tag, "_en"},   enVec(),    phases[k]);
            chk({tag, "_pc"},   32'(oPC),   32'(pcM));
            chk({tag, "_busy"}, 32'(oBUSY), 32'd1);
            chkRet({tag, "_ret"});
            start = 1'($urandom);
            if (phases[k] == PH_EX) begin
                brTake = br; brOff = PC_W'(off); ret = r;
            end else begin
                brTake = 1'($urandom); brOff = PC_W'($urandom); ret = 1'($urandom);
            end
            if (phases[k] == PH_MEM) begin
                stall = (memIdx < stalls);
                memIdx++;
            end else begin
                stall = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 0; stall = 0; brTake = 0; ret = 0;
        retM++;
        t = pcM + 1 + (br ? off : 0);
        if (r) haltM = 1;
        else if (t >= PROG_LEN) begin haltM = 1; faultM = 1; end
        else pcM = t;
        if (haltM) begin
            chkHalted({tag, "_halted"});
            start = 1;
            repeat (2) @(negedge clk);
            start = 0;
            chkHalted({tag, "_halt_hold"});
        end
    endtask

    initial begin
        // Reset and first two instructions
        doReset("rst0");
        doStart();
        runInstr("i0", 0, 0, 0, 0);
        runInstr("i1", 0, 0, 0, 0);
        // Stall of three cycles at PC 2
        runInstr("stall", 3, 0, 0, 0);
        chk("stall_nextpc", 32'(oPC), 32'd3);
        runInstr("i3", 0, 0, 0, 0);
        // Branch at PC 4 with offset 5
        runInstr("br", 0, 1, 5, 0);
        chk("br_nextpc", 32'(oPC), 32'd10);

        // RET and branch together at PC 4
        doReset("rst1");
        doStart();
        for (int i = 0; i < 4; i++) runInstr("walk", 0, 0, 0, 0);
        runInstr("retbr", 0, 1, 5, 1);
        chk("retbr_pc",    32'(oPC),    32'd4);
        chk("retbr_fault", 32'(oFAULT), 32'd0);

        // Out-of-range branch at PC 14
        doReset("rst2");
        doStart();
        runInstr("jmp14", 1, 1, 13, 0);
        runInstr("oor", 0, 1, 3, 0);
        chk("oor_pc",    32'(oPC),    32'd14);
        chk("oor_fault", 32'(oFAULT), 32'd1);

        // Falling off the end at PC 15
        doReset("rst3");
        doStart();
        runInstr("jmp15", 0, 1, 14, 0);
        runInstr("end", 2, 0, 0, 0);
        chk("end_pc",    32'(oPC),    32'd15);
        chk("end_fault", 32'(oFAULT), 32'd1);

        // Reset in the middle of a stall, then restart from PC 0
        doReset("rst4");
        doStart();
        runInstr("pre", 0, 0, 0, 0);
        chk("ms_if", enVec(), PH_IF);
        @(negedge clk);
        @(negedge clk);
        stall = 1; start = 1;
        @(negedge clk);
        chk("ms_mem0", enVec(), PH_MEM);
        @(negedge clk);
        chk("ms_mem1", enVec(), PH_MEM);
        chk("ms_pc",   32'(oPC), 32'd1);
        doReset("midstall");
        doStart();
        runInstr("restart", 0, 0, 0, 0);
        chk("restart_pc", 32'(oPC), 32'd1);

        // Six instructions ending in RET
        doReset("rst5");
        doStart();
        for (int i = 0; i < 5; i++) runInstr("six", int'($urandom_range(0, 2)), 0, 0, 0);
        runInstr("six_ret", 0, 0, 0, 1);
        chk("six_pc", 32'(oPC), 32'd5);
`ifdef SEQ_RETIRE_CNT_EN
        chk("six_retired", oRETIRED, 32'd6);
`endif

        // Random instruction streams
        for (int run = 0; run < 8; run++) begin
            doReset("rrst");
            doStart();
            for (int n = 0; n < 30 && !haltM; n++) begin
                runInstr("rnd", int'($urandom_range(0, 3)), 1'($urandom),
                         int'($urandom_range(0, 6)), ($urandom_range(0, 11) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
        $finish;
    end

endmodule

// File: doc/bpf_fetch_sequencer.md
# bpf_fetch_sequencer

Multi-cycle phase controller for the BPF CPU core. Owns the program counter and steps each instruction through IF, ID, EX, MEM and WB by driving one-hot stage enables to the fetch, decode, execute and writeback blocks. Applies branch offsets reported by execute, stretches MEM while memory stalls, and halts on return or on an out-of-program target. Sits between the top level and the fetch/instruction-ROM stage; fetch reads `oPC` while `oEN_IF` is high.

## Interface
- `PC_W`, default 8: program counter width.
- `PROG_LEN`, default 256: number of valid instruction slots. Must be ≤ 2^`PC_W`.
- `iCLK_IF` in 1: single system clock. All state updates on the rising edge.
- `iRST` in 1: reset, asynchronous, active-high.
- `iSTART` in 1: begin execution. Sampled in IDLE only.
- `iSTALL` in 1: memory not ready. Sampled in MEM only.
- `iBR_TAKE` in 1: branch taken. Sampled in EX only.
- `iBR_OFF` in `PC_W`: forward jump offset, unsigned. Sampled with `iBR_TAKE`.
- `iRET` in 1: current instruction is RET. Sampled in EX only.
- `oPC` out `PC_W`: address of the current instruction.
- `oEN_IF`, `oEN_ID`, `oEN_EX`, `oEN_MEM`, `oEN_WB` out 1 each: one-hot stage enables.
- `oBUSY` out 1: state is neither IDLE nor HALT.
- `oHALT` out 1: sticky halt. Cleared only by reset.
- `oFAULT` out 1: sticky out-of-range flag. Cleared only by reset.

## Operation
- States: IDLE, IF, ID, EX, MEM, WB, HALT. State is a registered Moore machine; every enable is decoded directly from state.
- Transitions:
  - IDLE→IF when `iSTART`=1.
  - IF→ID→EX→MEM, unconditionally.
  - MEM→MEM while `iSTALL`=1, otherwise MEM→WB.
  - WB→IF normally; WB→HALT when a RET or a fault is pending.
  - HALT is absorbing until reset.
- EX cycle latches `ret_p`=`iRET`, `br_p`=`iBR_TAKE`, `off_q`=`iBR_OFF`.
- Next-PC target:
  - Taken branch: `oPC`+1+`off_q`.
  - Otherwise: `oPC`+1.
  - Computed at width `PC_W`+1, with no wrap.
- Fault: target ≥ `PROG_LEN` and `ret_p`=0. Falling off the program end is therefore a fault.
- WB edge:
  - With `ret_p`: `oHALT`←1, PC unchanged.
  - With a fault: `oHALT`←1, `oFAULT`←1, PC unchanged, so it points at the faulting instruction.
  - Otherwise: PC←target.
- Priority: `iRET` over `iBR_TAKE` when both are asserted in the same EX cycle.
- Inputs outside their sampling state are ignored, including `iSTART` while busy or halted.

## Timing
- Reset values:
  - state IDLE, `oPC`=0.
  - all `oEN_*`=0.
  - `oBUSY`=0, `oHALT`=0, `oFAULT`=0.
  - internal `ret_p`/`br_p`/`off_q`=0.
- Reset asserted mid-instruction (any state, including a stall) returns to these values immediately; there is no partial writeback.
- Latency:
  - `iSTART` high at edge N: `oEN_IF` high in cycle N+1.
  - Unstalled instruction: 5 cycles.
  - Each stalled MEM cycle adds 1 cycle.
- `oPC` is stable from IF through WB and changes only on the WB→IF edge. Fetch may register its instruction word at the end of IF.
- HALT: all enables 0, `oBUSY`=0, `oPC` frozen.

## Configuration
- `SEQ_RETIRE_CNT_EN`:
  - Defined: adds port `oRETIRED` out 32, reset 0. It increments by 1 on every WB edge, including the RET or faulting instruction, wraps at 2^32, and freezes in HALT.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `bpf_seq_pkg`:
  - state enum.
  - `PC_W` default.
  - stage-enable bit indices.
- One sub-module, `seq_pc_target`: combinational next-PC and fault computation from `oPC`, `br_p`, `off_q` and `PROG_LEN`.
- Top block holds:
  - the state register.
  - PC, latch and sticky-flag registers.
  - enable decode.
  - the optional counter.

## Test plan
- **Reset and start:** reset, then pulse `iSTART`. Expect `oEN_IF` next cycle with `oPC`=0, then the exact one-hot sequence IF,ID,EX,MEM,WB; the second IF has `oPC`=1.
- **Stall:** `iSTALL`=1 for 3 MEM cycles at PC 2. Expect `oEN_MEM` held 4 cycles total, instruction 8 cycles, next `oPC`=3.
- **Branch:** at PC 4, `iBR_TAKE`=1 with `iBR_OFF`=5. Expect next `oPC`=10. With `iRET`=1 also asserted in the same EX cycle, expect HALT with `oPC`=4 and `oFAULT`=0.
- **Out-of-range target:** `PROG_LEN`=16, at PC 14 with `iBR_OFF`=3. Expect `oHALT`=1, `oFAULT`=1, `oPC`=14. With no branch at PC 15, expect a fault with `oPC`=15.
- **Reset mid-stall:** assert `iRST` mid-stall. Expect all outputs at reset values immediately and `iSTART` to restart from PC 0. `iSTART` pulsed while busy has no effect.
- **Retire counter:** with `SEQ_RETIRE_CNT_EN`, run 6 instructions ending in RET. Expect `oRETIRED`=6, held in HALT.
